vector_exec_unit: RTL and testbench

Execute-side core of the 6-lane × 8-bit vector CPU. It combines three functions:
- the instruction decoder (`control_unit` function), which produces control signals from the opcode field `Instr[31:25]` in the decode stage;
- six parallel ALU lanes (`alu_lanes` function), evaluated combinationally in the execute stage;
- the load/store address adder (`address_offset` function).

A registered per-lane flag state gives the block its single clock and synchronous reset.

---
 rtl/vec_pkg.sv | 29 ++
 rtl/vec_alu_lane.sv | 65 ++++++
 rtl/vector_exec_unit.sv | 103 ++++++++++
 tb/tb_vector_exec_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the 6-lane x 8-bit vector execute unit: geometry,
// ALU opcodes, instruction type codes and the packed lane-vector type.
package vec_pkg;

  localparam int N = 8;
  localparam int R = 6;
  localparam int I = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_CMP = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    TYPE_NOP  = 2'b00,
    TYPE_DATA = 2'b01,
    TYPE_MEM  = 2'b10,
    TYPE_CTRL = 2'b11
  } instr_type_e;

  typedef logic [R-1:0][N-1:0] lane_vec_t;

endpackage

// File: rtl/vec_alu_lane.sv
// One N-bit ALU lane returning its result and {C, Z} flags.
// Optional clamping of ADD/SUB is enabled by defining VEC_ALU_SATURATE_EN.
module vec_alu_lane
  import vec_pkg::*;
#(
  parameter int N = vec_pkg::N
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  alu_op_e      op_i,
  output logic [N-1:0] result_o,
  output logic [1:0]   flags_o
);

`ifdef VEC_ALU_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Clamp on carry-out (ADD) or borrow (SUB); the flag itself stays unclamped.
  function automatic logic [N-1:0] sat_add(input logic [N:0] s);
    return (SAT_EN && s[N]) ? {N{1'b1}} : s[N-1:0];
  endfunction

  function automatic logic [N-1:0] sat_sub(input logic [N:0] d);
    return (SAT_EN && d[N]) ? {N{1'b0}} : d[N-1:0];
  endfunction

  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N:0]   shl;
  logic [N:0]   shr;
  logic [2:0]   shamt;
  logic [N-1:0] res;
  logic         carry;

  assign shamt = b_i[2:0];
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  // One guard bit on each side catches the last bit shifted out (0 for shamt 0).
  assign shl   = {1'b0, a_i} << shamt;
  assign shr   = {a_i, 1'b0} >> shamt;

  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (op_i)
      ALU_ADD: begin res = sat_add(sum);  carry = sum[N];  end
      ALU_SUB: begin res = sat_sub(diff); carry = diff[N]; end
      ALU_AND: res = a_i & b_i;
      ALU_OR:  res = a_i | b_i;
      ALU_XOR: res = a_i ^ b_i;
      ALU_SHL: begin res = shl[N-1:0]; carry = shl[N]; end
      ALU_SHR: begin res = shr[N:1];   carry = shr[0]; end
      ALU_CMP: begin res = '0;         carry = diff[N]; end
      default: begin res = '0;         carry = 1'b0;    end
    endcase
  end

  assign result_o = res;
  // CMP drives a zero result, so its Z must come from the difference.
  assign flags_o  = {carry, (op_i == ALU_CMP) ? (diff[N-1:0] == '0) : (res == '0)};

endmodule

// File: rtl/vector_exec_unit.sv
// Execute-side core: opcode decode, R parallel ALU lanes, load/store address
// adder and registered per-lane flags. Optional macro: VEC_ALU_SATURATE_EN.
module vector_exec_unit
  import vec_pkg::*;
#(
  parameter int N = vec_pkg::N,
  parameter int R = vec_pkg::R,
  parameter int I = vec_pkg::I
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            Id,
  output logic                  RegWrite,
  output logic                  MemtoReg,
  output logic                  MemWrite,
  output logic                  FlagsWrite,
  output logic                  RegSrc,
  output logic [1:0]            VSIFlag,
  output logic [2:0]            ALUControl,
  input  logic [R-1:0][N-1:0]   SrcAE,
  input  logic [R-1:0][N-1:0]   SrcBE,
  input  logic [3:0]            SrcBiE,
  input  logic [N-1:0]          ImmE,
  input  logic [1:0]            VSIFlagE,
  input  logic [2:0]            ALUControlE,
  input  logic                  FlagsWriteE,
  output logic [R-1:0][N-1:0]   ALUOutput,
  output logic [R-1:0][1:0]     ALUFlags,
  output logic [R-1:0][1:0]     FlagsQ,
  output logic [I-1:0]          AddressE
);

  // Decode stage: Id = {type[1:0], op[2:0], IS[1:0]}
  always_comb begin
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    MemWrite   = 1'b0;
    FlagsWrite = 1'b0;
    RegSrc     = 1'b0;
    VSIFlag    = 2'b00;
    ALUControl = 3'b000;
    case (instr_type_e'(Id[6:5]))
      TYPE_DATA: begin
        ALUControl = Id[4:2];
        VSIFlag    = Id[1:0];
        if (alu_op_e'(Id[4:2]) == ALU_CMP) FlagsWrite = 1'b1;
        else                               RegWrite   = 1'b1;
      end
      TYPE_MEM: begin
        VSIFlag = {1'b1, Id[3]};
        if (!Id[4]) begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end else begin
          MemWrite = 1'b1;
          RegSrc   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Execute stage: operand B selection and lane ALUs
  logic unused_bi;
  assign unused_bi = ^SrcBiE[2:0];

  for (genvar g = 0; g < R; g++) begin : g_lane
    logic [N-1:0] b_sel;

    always_comb begin
      if (VSIFlagE[1])                   b_sel = ImmE;
      else if (VSIFlagE[0] || SrcBiE[3]) b_sel = SrcBE[0];
      else                               b_sel = SrcBE[g];
    end

    vec_alu_lane #(.N(N)) u_lane (
      .a_i      (SrcAE[g]),
      .b_i      (b_sel),
      .op_i     (alu_op_e'(ALUControlE)),
      .result_o (ALUOutput[g]),
      .flags_o  (ALUFlags[g])
    );
  end

  // Effective address from the low four lanes plus zero-extended immediate
  logic [4*N-1:0] addr_base;
  assign addr_base = {SrcAE[3], SrcAE[2], SrcAE[1], SrcAE[0]};
  assign AddressE  = I'(addr_base) + I'(ImmE);

  // Flag state register
  logic [R-1:0][1:0] flags_d;
  logic [R-1:0][1:0] flags_q;

  assign flags_d = FlagsWriteE ? ALUFlags : flags_q;

  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign FlagsQ = flags_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Self-checking bench for vector_exec_unit; expectations are queued when
// stimulus is driven and popped when the outputs are sampled.
module tb_vector_exec_unit;
  localparam int N = 8;
  localparam int R = 6;
  localparam int I = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [6:0]          Id;
  logic                RegWrite, MemtoReg, MemWrite, FlagsWrite, RegSrc;
  logic [1:0]          VSIFlag;
  logic [2:0]          ALUControl;
  logic [R-1:0][N-1:0] SrcAE, SrcBE;
  logic [3:0]          SrcBiE;
  logic [N-1:0]        ImmE;
  logic [1:0]          VSIFlagE;
  logic [2:0]          ALUControlE;
  logic                FlagsWriteE;
  logic [R-1:0][N-1:0] ALUOutput;
  logic [R-1:0][1:0]   ALUFlags, FlagsQ;
  logic [I-1:0]        AddressE;

  logic [63:0] exp_q[$];
  logic [63:0] e;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  vector_exec_unit #(.N(N), .R(R), .I(I)) dut (
    .clk(clk), .reset(reset), .Id(Id),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .FlagsWrite(FlagsWrite), .RegSrc(RegSrc), .VSIFlag(VSIFlag), .ALUControl(ALUControl),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .SrcBiE(SrcBiE), .ImmE(ImmE),
    .VSIFlagE(VSIFlagE), .ALUControlE(ALUControlE), .FlagsWriteE(FlagsWriteE),
    .ALUOutput(ALUOutput), .ALUFlags(ALUFlags), .FlagsQ(FlagsQ), .AddressE(AddressE)
  );

  // Behavioural lane reference written with integer arithmetic.
  function automatic void model_lane(input int a, input int b, input int op,
                                     output int res, output int c, output int z);
    int s;
    bit sat;
`ifdef VEC_ALU_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    s = b % 8;
    c = 0;
    case (op)
      0: begin c = (a + b > 255); res = (sat && c) ? 255 : (a + b) % 256; end
      1: begin c = (a < b);       res = (sat && c) ? 0 : (a - b + 256) % 256; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a * (1 << s)) % 256; c = (s == 0) ? 0 : (a >> (8 - s)) & 1; end
      6: begin res = a >> s;               c = (s == 0) ? 0 : (a >> (s - 1)) & 1; end
      default: begin res = 0; c = (a < b); end
    endcase
    z = (op == 7) ? (a == b) : (res == 0);
  endfunction

  function automatic logic [59:0] model_alu();
    logic [R-1:0][N-1:0] o;
    logic [R-1:0][1:0]   f;
    int b, r, c, z;
    for (int i = 0; i < R; i++) begin
      if (VSIFlagE[1])                   b = int'(ImmE);
      else if (VSIFlagE[0] || SrcBiE[3]) b = int'(SrcBE[0]);
      else                               b = int'(SrcBE[i]);
      model_lane(int'(SrcAE[i]), b, int'(ALUControlE), r, c, z);
      o[i] = 8'(r);
      f[i] = {c[0], z[0]};
    end
    return {o, f};
  endfunction

  task automatic set_alu(input logic [2:0] op, input logic [1:0] vsi, input logic [3:0] bi,
                         input logic [R-1:0][N-1:0] a, input logic [R-1:0][N-1:0] b,
                         input logic [N-1:0] imm);
    ALUControlE = op; VSIFlagE = vsi; SrcBiE = bi; SrcAE = a; SrcBE = b; ImmE = imm;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; FlagsWriteE = 1'b0;
    set_alu(3'b000, 2'b11, 4'd0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00}, '0, 8'd3);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h00000203);
    @(posedge clk); #1;
    e = exp_q.pop_front(); total++;
    if (FlagsQ !== e[11:0]) $display("FAIL reset_flagsq: got %h expected %h", FlagsQ, e[11:0]);
    else passed++;
    e = exp_q.pop_front(); total++;
    if (AddressE !== e[31:0]) $display("FAIL addr_during_reset: got %h expected %h", AddressE, e[31:0]);
    else passed++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_decode;
    logic [6:0] ids  [10] = '{7'b1000000, 7'b1010000, 7'b1011000, 7'b1001000, 7'b0100001,
                              7'b0110011, 7'b0111110, 7'b0000000, 7'b0010101, 7'b1111111};
    logic [9:0] exps [10] = '{10'b11000_10_000, 10'b00101_10_000, 10'b00101_11_000,
                              10'b11000_11_000, 10'b10000_01_000, 10'b10000_11_100,
                              10'b00010_10_111, 10'b0, 10'b0, 10'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      Id = ids[k];
      exp_q.push_back(64'(exps[k]));
      #1;
      e = exp_q.pop_front(); total++;
      if ({RegWrite, MemtoReg, MemWrite, FlagsWrite, RegSrc, VSIFlag, ALUControl} !== e[9:0])
        $display("FAIL decode_%b: got %b expected %b", ids[k],
                 {RegWrite, MemtoReg, MemWrite, FlagsWrite, RegSrc, VSIFlag, ALUControl}, e[9:0]);
      else passed++;
    end
  endtask

  task automatic test_address;
    longint sum;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0)      begin SrcAE = {8'h55, 8'h66, 8'h00, 8'h00, 8'h01, 8'h00}; ImmE = 8'd4; end
      else if (k == 1) begin SrcAE = {R{8'hFF}}; ImmE = 8'd1; end
      else begin
        for (int i = 0; i < R; i++) SrcAE[i] = 8'($urandom);
        ImmE = 8'($urandom);
      end
      sum = longint'(SrcAE[3]) * 64'h1000000 + longint'(SrcAE[2]) * 64'h10000
          + longint'(SrcAE[1]) * 64'h100 + longint'(SrcAE[0]) + longint'(ImmE);
      exp_q.push_back(64'(sum % 64'h100000000));
      #1;
      e = exp_q.pop_front(); total++;
      if (AddressE !== e[31:0]) $display("FAIL address_%0d: got %h expected %h", k, AddressE, e[31:0]);
      else passed++;
    end
  endtask

  task automatic test_add_imm;
    @(negedge clk);
    set_alu(3'b000, 2'b11, 4'd0, {R{8'd7}}, '0, 8'd5);
    exp_q.push_back({4'h0, {R{8'd12}}, 12'b0});
    #1;
    e = exp_q.pop_front(); total++;
    if ({ALUOutput, ALUFlags} !== e[59:0]) $display("FAIL add_imm: got %h expected %h", {ALUOutput, ALUFlags}, e[59:0]);
    else passed++;
    @(negedge clk);
    set_alu(3'b000, 2'b11, 4'd0, {R{8'd250}}, '0, 8'd10);
`ifdef VEC_ALU_SATURATE_EN
    exp_q.push_back({4'h0, {R{8'd255}}, {R{2'b10}}});
`else
    exp_q.push_back({4'h0, {R{8'd4}}, {R{2'b10}}});
`endif
    #1;
    e = exp_q.pop_front(); total++;
    if ({ALUOutput, ALUFlags} !== e[59:0]) $display("FAIL add_carry: got %h expected %h", {ALUOutput, ALUFlags}, e[59:0]);
    else passed++;
  endtask

  task automatic test_sub_scalar;
    @(negedge clk);
    set_alu(3'b001, 2'b01, 4'd0, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6},
            {8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd3}, 8'd0);
    exp_q.push_back({56'h0, 8'h0});
    exp_q.push_back({61'h0, 2'b11, 1'b1});
    exp_q.push_back(64'(model_alu()));
    #1;
    e = exp_q.pop_front(); total++;
    if ({ALUOutput[3], ALUFlags[3][0]} !== {e[7:0], 1'b1}) $display("FAIL sub_equal_lane: got %h/%b expected %h/1", ALUOutput[3], ALUFlags[3][0], e[7:0]);
    else passed++;
    e = exp_q.pop_front(); total++;
    if ({ALUFlags[5][1], ALUFlags[4][1], ALUFlags[3][1]} !== {e[2:1], 1'b0}) $display("FAIL sub_borrow: got %b expected %b", {ALUFlags[5][1], ALUFlags[4][1], ALUFlags[3][1]}, {e[2:1], 1'b0});
    else passed++;
    e = exp_q.pop_front(); total++;
    if ({ALUOutput, ALUFlags} !== e[59:0]) $display("FAIL sub_scalar_all: got %h expected %h", {ALUOutput, ALUFlags}, e[59:0]);
    else passed++;
  endtask

  task automatic test_random_ops;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ALUControlE = 3'(k % 8);
      VSIFlagE    = 2'($urandom_range(0, 3));
      SrcBiE      = 4'($urandom_range(0, 15));
      ImmE        = 8'($urandom);
      for (int i = 0; i < R; i++) begin
        SrcAE[i] = 8'($urandom);
        SrcBE[i] = (k % 5 == 0) ? SrcAE[i] : 8'($urandom);
      end
      if (k % 7 == 0) ImmE = SrcAE[0];
      exp_q.push_back(64'(model_alu()));
      #1;
      e = exp_q.pop_front(); total++;
      if ({ALUOutput, ALUFlags} !== e[59:0])
        $display("FAIL alu_op%0d_vsi%b_bi%h: got %h expected %h", ALUControlE, VSIFlagE, SrcBiE, {ALUOutput, ALUFlags}, e[59:0]);
      else passed++;
    end
  endtask

  task automatic test_cmp_flags;
    @(negedge clk);
    set_alu(3'b111, 2'b00, 4'd0, {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4}, {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4}, 8'd0);
    FlagsWriteE = 1'b1;
    exp_q.push_back(64'h0);
    exp_q.push_back({52'h0, {R{2'b01}}});
    #1;
    e = exp_q.pop_front(); total++;
    if (ALUOutput !== e[47:0]) $display("FAIL cmp_output: got %h expected %h", ALUOutput, e[47:0]);
    else passed++;
    @(posedge clk); #1;
    e = exp_q.pop_front(); total++;
    if (FlagsQ !== e[11:0]) $display("FAIL cmp_flagsq: got %b expected %b", FlagsQ, e[11:0]);
    else passed++;
    // Flags must hold while FlagsWriteE is low even though ALUFlags change.
    @(negedge clk);
    FlagsWriteE = 1'b0;
    set_alu(3'b001, 2'b00, 4'd0, {R{8'd1}}, {R{8'd2}}, 8'd0);
    exp_q.push_back({52'h0, {R{2'b01}}});
    @(posedge clk); #1;
    e = exp_q.pop_front(); total++;
    if (FlagsQ !== e[11:0]) $display("FAIL flags_hold: got %b expected %b", FlagsQ, e[11:0]);
    else passed++;
    // Reset and write on the same edge: reset wins.
    @(negedge clk);
    reset = 1'b1; FlagsWriteE = 1'b1;
    exp_q.push_back(64'h0);
    @(posedge clk); #1;
    e = exp_q.pop_front(); total++;
    if (FlagsQ !== e[11:0]) $display("FAIL reset_over_write: got %b expected %b", FlagsQ, e[11:0]);
    else passed++;
    @(negedge clk);
    reset = 1'b0; FlagsWriteE = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [11:0] exp_flags = '0;
    logic [59:0] m;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ALUControlE = 3'($urandom_range(0, 7));
      VSIFlagE    = 2'b00;
      SrcBiE      = 4'd0;
      ImmE        = 8'($urandom);
      for (int i = 0; i < R; i++) begin SrcAE[i] = 8'($urandom); SrcBE[i] = 8'($urandom); end
      FlagsWriteE = (k % 3 != 2);
      m = model_alu();
      if (FlagsWriteE) exp_flags = m[11:0];
      exp_q.push_back(64'(exp_flags));
      @(posedge clk); #1;
      e = exp_q.pop_front(); total++;
      if (FlagsQ !== e[11:0]) $display("FAIL b2b_flags_%0d: got %b expected %b", k, FlagsQ, e[11:0]);
      else passed++;
    end
    @(negedge clk); FlagsWriteE = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Id = '0; SrcAE = '0; SrcBE = '0; SrcBiE = '0; ImmE = '0;
    VSIFlagE = '0; ALUControlE = '0; FlagsWriteE = 1'b0;
    test_reset();
    test_decode();
    test_address();
    test_add_imm();
    test_sub_scalar();
    test_random_ops();
    test_cmp_flags();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
